// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial LSB-first adder sharing one full-adder cell, start/busy/done handshake
//   clk, rst_n (sync, active-low) | start, op_a, op_b in | busy, done, sum, carry_out registered out
module serial_add_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q, acc_d;
    logic [CW-1:0]    cnt_q;
    logic             c_q, carry_q, busy_q, done_q;
    logic             p, g1, s, g2, c_d;
    assign p     = a_q[0] ^ b_q[0];
    assign g1    = a_q[0] & b_q[0];
    assign s     = p ^ c_q;
    assign g2    = p & c_q;
    assign c_d   = g1 | g2;
    assign acc_d = {s, acc_q[WIDTH-1:1]};
    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= op_a;
                    b_q     <= op_b;
                    acc_q   <= '0;
                    c_q     <= 1'b0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    c_q   <= c_d;
                    acc_q <= acc_d;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                    // last bit: commit includes this edge's sum bit and carry
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_q   <= acc_d;
                        carry_q <= c_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: randomized self-checking bench for serial_add_sequencer at WIDTH 4 and 8
module tb_serial_add_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, start8;
    logic [3:0] op_a4, op_b4, sum4;
    logic [7:0] op_a8, op_b8, sum8;
    logic       busy4, done4, carry4, busy8, done8, carry8;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_add_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op_a(op_a4), .op_b(op_b4),
        .busy(busy4), .done(done4), .sum(sum4), .carry_out(carry4)
    );
    serial_add_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op_a(op_a8), .op_b(op_b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(carry8)
    );

    // Pulse start for one cycle, then wait for done; lat counts edges from the
    // start edge up to done, bsy counts cycles with busy high. lat=0 means timeout.
    task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int bsy);
        @(negedge clk);
        if (w8) begin op_a8 = a; op_b8 = b; start8 = 1'b1; end
        else begin op_a4 = a[3:0]; op_b4 = b[3:0]; start4 = 1'b1; end
        lat = 0;
        bsy = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            start8 = 1'b0;
            if (w8 ? busy8 : busy4) bsy++;
            if (w8 ? done8 : done4) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start4 = 1'b1;
        op_a4 = 4'd3;
        op_b4 = 4'd2;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy4, done4, sum4, carry4} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b sum=%0d carry=%b want all 0", busy4, done4, sum4, carry4);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_accept got busy=%b want 1", busy4);
        end
        start4 = 1'b0;
        for (int k = 0; k < 20 && !done4; k++) @(negedge clk);
        checks++;
        if ({carry4, sum4} !== 5'd5) begin
            errors++;
            $display("FAIL reset_first_op got %0d want 5", {carry4, sum4});
        end
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, bsy;
        run_op(1'b0, 8'd11, 8'd6, lat, bsy);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL basic_latency got %0d want 5", lat);
        end
        checks++;
        if (bsy !== 4) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d want 4", bsy);
        end
        checks++;
        if (sum4 !== 4'b0001 || carry4 !== 1'b1) begin
            errors++;
            $display("FAIL basic_result got sum=%0d carry=%b want sum=1 carry=1", sum4, carry4);
        end
        @(negedge clk);
        checks++;
        if (done4 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b want 0", done4);
        end
    endtask

    task automatic test_ripple;
        int lat, bsy;
        run_op(1'b0, 8'd15, 8'd1, lat, bsy);
        checks++;
        if (lat !== 5 || sum4 !== 4'd0 || carry4 !== 1'b1) begin
            errors++;
            $display("FAIL ripple_15p1 got lat=%0d sum=%0d carry=%b want lat=5 sum=0 carry=1", lat, sum4, carry4);
        end
        @(negedge clk);
        op_a4 = 4'd0;
        op_b4 = 4'd0;
        start4 = 1'b1;
        repeat (2) @(negedge clk);
        start4 = 1'b0;
        checks++;
        if (busy4 !== 1'b1 || sum4 !== 4'd0 || carry4 !== 1'b1) begin
            errors++;
            $display("FAIL ripple_hold got busy=%b sum=%0d carry=%b want busy=1 sum=0 carry=1", busy4, sum4, carry4);
        end
        for (int k = 0; k < 20 && !done4; k++) @(negedge clk);
        checks++;
        if (done4 !== 1'b1 || sum4 !== 4'd0 || carry4 !== 1'b0) begin
            errors++;
            $display("FAIL ripple_0p0 got done=%b sum=%0d carry=%b want done=1 sum=0 carry=0", done4, sum4, carry4);
        end
        @(negedge clk);
    endtask

    task automatic test_start_during_run;
        int dones = 0;
        @(negedge clk);
        op_a4 = 4'd3;
        op_b4 = 4'd4;
        start4 = 1'b1;
        @(negedge clk);
        op_a4 = 4'd9;
        op_b4 = 4'd10;
        repeat (2) @(negedge clk);
        start4 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done4) begin
                dones++;
                checks++;
                if (sum4 !== 4'd7 || carry4 !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_start_result got sum=%0d carry=%b want sum=7 carry=0", sum4, carry4);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL busy_start_done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_reset_mid_run;
        int dones = 0;
        int lat, bsy;
        @(negedge clk);
        op_a4 = 4'd5;
        op_b4 = 4'd9;
        start4 = 1'b1;
        repeat (3) @(negedge clk);
        start4 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (done4) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0 || busy4 !== 1'b0 || sum4 !== 4'd0 || carry4 !== 1'b0) begin
            errors++;
            $display("FAIL midrun_abort got dones=%0d busy=%b sum=%0d carry=%b want 0 0 0 0", dones, busy4, sum4, carry4);
        end
        run_op(1'b0, 8'd5, 8'd9, lat, bsy);
        checks++;
        if (lat !== 5 || sum4 !== 4'd14 || carry4 !== 1'b0) begin
            errors++;
            $display("FAIL midrun_fresh got lat=%0d sum=%0d carry=%b want lat=5 sum=14 carry=0", lat, sum4, carry4);
        end
        @(negedge clk);
    endtask

    task automatic test_held_start;
        int t = 0;
        int prev = -1;
        int seen = 0;
        @(negedge clk);
        op_a8 = 8'd200;
        op_b8 = 8'd100;
        start8 = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (done8) begin
                seen++;
                checks++;
                if (sum8 !== 8'd44 || carry8 !== 1'b1) begin
                    errors++;
                    $display("FAIL held_result got sum=%0d carry=%b want sum=44 carry=1", sum8, carry8);
                end
                if (prev >= 0) begin
                    checks++;
                    if (k - prev !== 10) begin
                        errors++;
                        $display("FAIL held_period got %0d want 10", k - prev);
                    end
                end
                prev = k;
            end
        end
        start8 = 1'b0;
        checks++;
        if (seen < 4) begin
            errors++;
            $display("FAIL held_done_count got %0d want >=4", seen);
        end
        for (int k = 0; k < 12 && (busy8 || done8); k++) @(negedge clk);
        t = 0;
    endtask

    task automatic test_random;
        int lat, bsy;
        logic [7:0] a, b;
        logic [8:0] ref_sum;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            ref_sum = 9'(a) + 9'(b);
            run_op(1'b1, a, b, lat, bsy);
            checks++;
            if (lat !== 9 || bsy !== 8 || {carry8, sum8} !== ref_sum) begin
                errors++;
                $display("FAIL random %0d+%0d got lat=%0d busy=%0d result=%0d want lat=9 busy=8 result=%0d",
                         a, b, lat, bsy, {carry8, sum8}, ref_sum);
            end
        end
    endtask

    initial begin
        start8 = 1'b0;
        op_a8 = '0;
        op_b8 = '0;
        test_reset;
        test_basic;
        test_ripple;
        test_start_during_run;
        test_reset_mid_run;
        test_held_start;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
